// File: rtl/pcpi_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_muldiv_seq
// Brief    : Sequential RV32M multiply/divide coprocessor on the PCPI port.
//            Define PCPI_MULDIV_DIV_EN to include the divide variants.
// Revision : 1.0  initial release
// ============================================================================
module pcpi_muldiv_seq #(
    parameter int STEPS_AT_ONCE = 1,
    parameter int CARRY_CHAIN   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] N_MUL  = 7'(32 / STEPS_AT_ONCE);
    localparam logic [6:0] N_MULH = 7'(64 / STEPS_AT_ONCE);
    localparam int         NSEG   = 64 / ((CARRY_CHAIN == 0) ? 64 : CARRY_CHAIN);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] mplier_q, mplier_d;
    logic [63:0] sum_q, sum_d;
    logic [63:0] car_q, car_d;
    logic [31:0] rd_q, rd_d;

    logic [2:0]  w_f3;
    logic        w_match;
    logic        w_s1, w_s2;
    logic [63:0] w_prod;
    logic [31:0] w_result;

    assign w_f3 = pcpi_insn[14:12];

`ifdef PCPI_MULDIV_DIV_EN
    assign w_match = pcpi_valid && (pcpi_insn[6:0] == 7'b0110011) &&
                     (pcpi_insn[31:25] == 7'b0000001);
`else
    assign w_match = pcpi_valid && (pcpi_insn[6:0] == 7'b0110011) &&
                     (pcpi_insn[31:25] == 7'b0000001) && !pcpi_insn[14];
`endif

    // MULH and MULHSU take rs1 as signed; only MULH takes rs2 as signed.
    assign w_s1 = ((w_f3[1:0] == 2'b01) || (w_f3[1:0] == 2'b10)) && pcpi_rs1[31];
    assign w_s2 = (w_f3[1:0] == 2'b01) && pcpi_rs2[31];

    logic [63:0] w_a [0:STEPS_AT_ONCE];
    logic [63:0] w_b [0:STEPS_AT_ONCE];
    logic [63:0] w_s [0:STEPS_AT_ONCE];
    logic [63:0] w_c [0:STEPS_AT_ONCE];

    assign w_a[0] = mcand_q;
    assign w_b[0] = mplier_q;
    assign w_s[0] = sum_q;
    assign w_c[0] = car_q;

    genvar s, g;
    generate
        for (s = 0; s < STEPS_AT_ONCE; s++) begin : g_step
            wire [63:0] w_add;
            wire [63:0] w_sn;
            wire [63:0] w_cn;

            assign w_add = w_b[s][0] ? w_a[s] : 64'd0;

            if (CARRY_CHAIN == 0) begin : g_csa
                assign w_sn = w_s[s] ^ w_c[s] ^ w_add;
                assign w_cn = ((w_s[s] & w_c[s]) | (w_s[s] & w_add) | (w_c[s] & w_add)) << 1;
            end else begin : g_chain
                localparam logic [CARRY_CHAIN-1:0] C_SEG_ONE = CARRY_CHAIN'(1);
                // Carries only ever sit on segment LSBs, so each segment sum fits CARRY_CHAIN+1 bits.
                assign w_cn[CARRY_CHAIN-1:0] = '0;
                for (g = 0; g < NSEG; g++) begin : g_seg
                    if (g == NSEG - 1) begin : g_top
                        assign w_sn[g*CARRY_CHAIN +: CARRY_CHAIN] =
                            w_s[s][g*CARRY_CHAIN +: CARRY_CHAIN] +
                            w_c[s][g*CARRY_CHAIN +: CARRY_CHAIN] +
                            w_add[g*CARRY_CHAIN +: CARRY_CHAIN];
                    end else begin : g_low
                        wire [CARRY_CHAIN:0] w_seg;
                        assign w_seg = {1'b0, w_s[s][g*CARRY_CHAIN +: CARRY_CHAIN]} +
                                       {1'b0, w_c[s][g*CARRY_CHAIN +: CARRY_CHAIN]} +
                                       {1'b0, w_add[g*CARRY_CHAIN +: CARRY_CHAIN]};
                        assign w_sn[g*CARRY_CHAIN +: CARRY_CHAIN] = w_seg[CARRY_CHAIN-1:0];
                        assign w_cn[(g+1)*CARRY_CHAIN +: CARRY_CHAIN] =
                            w_seg[CARRY_CHAIN] ? C_SEG_ONE : '0;
                    end
                end
            end

            assign w_a[s+1] = w_a[s] << 1;
            assign w_b[s+1] = w_b[s] >> 1;
            assign w_s[s+1] = w_sn;
            assign w_c[s+1] = w_cn;
        end
    endgenerate

    assign w_prod = w_s[STEPS_AT_ONCE] + w_c[STEPS_AT_ONCE];

`ifdef PCPI_MULDIV_DIV_EN
    localparam logic [6:0] N_DIV = 7'd32;

    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        dz_q, dz_d;

    logic        w_n1, w_n2;
    logic [32:0] w_rem_sh;
    logic        w_take;
    logic [31:0] w_rem_n, w_qmag, w_quot, w_rem_fin;

    assign w_n1 = !w_f3[0] && pcpi_rs1[31];
    assign w_n2 = !w_f3[0] && pcpi_rs2[31];

    // Restoring step: quotient bits shift into the dividend register from the bottom.
    assign w_rem_sh  = {rem_q, dvd_q[31]};
    assign w_take    = w_rem_sh >= {1'b0, dvs_q};
    assign w_rem_n   = w_take ? 32'(w_rem_sh - {1'b0, dvs_q}) : w_rem_sh[31:0];
    assign w_qmag    = {dvd_q[30:0], w_take};
    assign w_quot    = dz_q ? 32'hFFFF_FFFF : (negq_q ? -w_qmag : w_qmag);
    assign w_rem_fin = negr_q ? -w_rem_n : w_rem_n;
`endif

    always_comb begin
        w_result = w_prod[31:0];
        case (op_q)
            3'b001, 3'b010, 3'b011: w_result = w_prod[63:32];
`ifdef PCPI_MULDIV_DIV_EN
            3'b100, 3'b101:         w_result = w_quot;
            3'b110, 3'b111:         w_result = w_rem_fin;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sum_d    = sum_q;
        car_d    = car_q;
        rd_d     = rd_q;
`ifdef PCPI_MULDIV_DIV_EN
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_match) begin
                    state_d  = RUN;
                    op_d     = w_f3;
                    mcand_d  = {{32{w_s1}}, pcpi_rs1};
                    mplier_d = {{32{w_s2}}, pcpi_rs2};
                    sum_d    = '0;
                    car_d    = '0;
                    cnt_d    = (w_f3[1:0] == 2'b00) ? N_MUL : N_MULH;
`ifdef PCPI_MULDIV_DIV_EN
                    if (w_f3[2]) cnt_d = N_DIV;
                    dvd_d  = w_n1 ? -pcpi_rs1 : pcpi_rs1;
                    dvs_d  = w_n2 ? -pcpi_rs2 : pcpi_rs2;
                    rem_d  = '0;
                    negq_d = w_n1 ^ w_n2;
                    negr_d = w_n1;
                    dz_d   = (pcpi_rs2 == 32'd0);
`endif
                end
            end
            RUN: begin
                // A withdrawn instruction wins over completion on the same edge.
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end else begin
                    cnt_d    = cnt_q - 7'd1;
                    mcand_d  = w_a[STEPS_AT_ONCE];
                    mplier_d = w_b[STEPS_AT_ONCE];
                    sum_d    = w_s[STEPS_AT_ONCE];
                    car_d    = w_c[STEPS_AT_ONCE];
`ifdef PCPI_MULDIV_DIV_EN
                    dvd_d    = w_qmag;
                    rem_d    = w_rem_n;
`endif
                    if (cnt_q == 7'd1) begin
                        state_d = DONE;
                        rd_d    = w_result;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sum_q    <= '0;
            car_q    <= '0;
            rd_q     <= '0;
`ifdef PCPI_MULDIV_DIV_EN
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sum_q    <= sum_d;
            car_q    <= car_d;
            rd_q     <= rd_d;
`ifdef PCPI_MULDIV_DIV_EN
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
`endif
        end
    end

    assign pcpi_wait  = (state_q == RUN);
    assign pcpi_ready = (state_q == DONE);
    assign pcpi_wr    = (state_q == DONE);
    assign pcpi_rd    = rd_q;

endmodule
`default_nettype wire
